systolic_seq: RTL and testbench

- Sequencer for a DIM x DIM systolic array of 8-bit-in/16-bit-accumulate MAC cells.
- Accepts commands from the host/MMIO layer over a valid/ready handshake.
- Drives the array's global enable, per-row C write enables, and the index/valid strobes for the external A/B skew feeders.
- Signals completion with a one-cycle done pulse.
- Sits between the MMIO command decoder and the array plus its A/B/C buffers; it carries no datapath values.

---
 rtl/systolic_seq_pkg.sv | 24 ++
 rtl/systolic_seq_counter.sv | 31 +++
 rtl/systolic_seq.sv | 125 ++++++++++++
 tb/tb_systolic_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_C  = 2'd0,
    OP_COMPUTE = 2'd1,
    OP_NOP2    = 2'd2,
    OP_NOP3    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADC  = 3'd1,
    S_CLEAR  = 3'd2,
    S_STREAM = 3'd3,
    S_FIN    = 3'd4
  } state_e;

  // Operands of a DIM-wide skewed wavefront need 3*DIM-2 cycles to drain.
  function automatic int unsigned stream_len(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_seq_counter.sv
// Loadable up-counter with terminal-count flag; wraps to zero after LAST.
module seq_counter #(
  parameter int           W    = 4,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count_nxt,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (load)    count_nxt = load_val;
    else if (en) count_nxt = tc ? '0 : count + W'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/systolic_seq.sv
// Command sequencer for a DIM x DIM systolic MAC array.
// Optional auto-clear of C before COMPUTE: define SYSTOLIC_SEQ_AUTO_CLEAR_EN.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(3 * DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [$clog2(DIM)-1:0] cmd_row,
  output logic                   arr_en,
  output logic [DIM-1:0]         arr_wren,
  output logic                   c_zero,
  output logic [CNT_W-1:0]       feed_idx,
  output logic                   feed_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int ROW_W = $clog2(DIM);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_LOADC  = S_LOADC;
`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
  localparam logic [2:0] ST_CLEAR  = S_CLEAR;
`endif
  localparam logic [2:0] ST_STREAM = S_STREAM;
  localparam logic [2:0] ST_FIN    = S_FIN;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(stream_len(DIM) - 1);

  logic [2:0]       state_q, state_d;
  logic [DIM-1:0]   row_onehot, wren_d;
  logic [CNT_W-1:0] cnt_nxt, feed_idx_d;
  logic             cnt_tc;

  seq_counter #(
    .W    (CNT_W),
    .LAST (LAST)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q != ST_STREAM),
    .load_val  ('0),
    .en        (state_q == ST_STREAM),
    .count_nxt (cnt_nxt),
    .tc        (cnt_tc)
  );

  // Rows beyond DIM-1 (non power-of-two DIM) decode to no write at all.
  always_comb begin
    row_onehot = '0;
    for (int i = 0; i < DIM; i++) row_onehot[i] = (cmd_row == ROW_W'(i));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_LOAD_C:  state_d = ST_LOADC;
`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
            OP_COMPUTE: state_d = ST_CLEAR;
`else
            OP_COMPUTE: state_d = ST_STREAM;
`endif
            default:    state_d = ST_FIN;
          endcase
        end
      ST_LOADC:  state_d = ST_FIN;
`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
      ST_CLEAR:  state_d = ST_STREAM;
`endif
      ST_STREAM: if (cnt_tc) state_d = ST_FIN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they appear with the state.
  always_comb begin
    wren_d = '0;
    if (state_d == ST_LOADC) wren_d = row_onehot;
`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
    if (state_d == ST_CLEAR) wren_d = '1;
`endif
    feed_idx_d = (state_d == ST_STREAM) ? cnt_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      arr_en     <= 1'b0;
      arr_wren   <= '0;
      feed_idx   <= '0;
      feed_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_ready  <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      done       <= (state_d == ST_FIN);
      arr_en     <= (state_d == ST_STREAM);
      arr_wren   <= wren_d;
      feed_idx   <= feed_idx_d;
      feed_valid <= (state_d == ST_STREAM) && (feed_idx_d < CNT_W'(DIM));
    end
  end

`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_zero <= 1'b0;
    else        c_zero <= (state_d == ST_CLEAR);
  end
`else
  assign c_zero = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq at DIM=4; honours SYSTOLIC_SEQ_AUTO_CLEAR_EN.
module tb_systolic_seq;

  localparam int DIM   = 4;
  localparam int CNT_W = $clog2(3 * DIM);

`ifdef SYSTOLIC_SEQ_AUTO_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int STREAM   = 3 * DIM - 2;
  localparam int LAT_COMP = 3 * DIM - 1 + CLR;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [1:0]       cmd_row = 2'd0;
  logic             arr_en;
  logic [DIM-1:0]   arr_wren;
  logic             c_zero;
  logic [CNT_W-1:0] feed_idx;
  logic             feed_valid;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  systolic_seq #(.DIM(DIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .arr_en     (arr_en),
    .arr_wren   (arr_wren),
    .c_zero     (c_zero),
    .feed_idx   (feed_idx),
    .feed_valid (feed_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]     op;
    logic [1:0]     row;
    logic [DIM-1:0] exp_wren;
    int             exp_wren_cyc;
    int             exp_en;
    int             exp_cz;
    int             exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Present a command at a negedge and return at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] row);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v);
    int k, en_cnt, first_en, last_en, wren_cnt, cz_cnt, done_k;
    logic [DIM-1:0] wren_val;
    en_cnt = 0; first_en = -1; last_en = -1; wren_cnt = 0; cz_cnt = 0; done_k = 0;
    wren_val = '0;
    issue(v.op, v.row);
    cmd_valid = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (arr_en) begin
        check("feed_idx", 32'(feed_idx), 32'(en_cnt));
        check("feed_valid", {31'd0, feed_valid}, (en_cnt < DIM) ? 32'd1 : 32'd0);
        if (first_en < 0) first_en = k;
        last_en = k;
        en_cnt++;
      end else begin
        check("idle feed", {27'd0, feed_valid, feed_idx}, 32'd0);
      end
      if (arr_wren != '0) begin
        wren_cnt++;
        wren_val = arr_wren;
      end
      if (c_zero) cz_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check("done latency", 32'(done_k), 32'(v.exp_lat));
    check("arr_en cycles", 32'(en_cnt), 32'(v.exp_en));
    if (v.exp_en > 0) begin
      check("arr_en contiguous", 32'(last_en - first_en + 1), 32'(v.exp_en));
      check("done after last arr_en", 32'(done_k - last_en), 32'd1);
    end
    check("arr_wren value", 32'(wren_val), 32'(v.exp_wren));
    check("arr_wren cycles", 32'(wren_cnt), 32'(v.exp_wren_cyc));
    check("c_zero cycles", 32'(cz_cnt), 32'(v.exp_cz));
    @(negedge clk);
    check("post idle", {29'd0, done, busy, cmd_ready}, 32'b001);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'd0, 2'd2, 4'b0100, 1, 0, 0, 2};
    vecs[1] = '{2'd0, 2'd0, 4'b0001, 1, 0, 0, 2};
    vecs[2] = '{2'd0, 2'd3, 4'b1000, 1, 0, 0, 2};
    vecs[3] = '{2'd1, 2'd0, CLR ? 4'b1111 : 4'b0000, CLR, STREAM, CLR, LAT_COMP};
    vecs[4] = '{2'd2, 2'd1, 4'b0000, 0, 0, 0, 1};
    vecs[5] = '{2'd3, 2'd3, 4'b0000, 0, 0, 0, 1};
    vecs[6] = '{2'd0, 2'd1, 4'b0010, 1, 0, 0, 2};

    // Reset state, sampled both during and after reset.
    #12;
    check("reset outputs", {arr_wren, c_zero, arr_en, done, busy, cmd_ready}, 32'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset outputs", {arr_wren, c_zero, arr_en, done, busy, cmd_ready}, 32'b1);
    check("post-reset feed", {27'd0, feed_valid, feed_idx}, 32'd0);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Back-to-back: a LOAD_C held while COMPUTE runs is stalled, then runs once.
    begin
      int stall_bad, wren_cnt, k;
      stall_bad = 0;
      wren_cnt  = 0;
      issue(2'd1, 2'd0);
      cmd_op  = 2'd0;
      cmd_row = 2'd1;
      for (k = 0; k < 40 && !done; k++) begin
        if (cmd_ready) stall_bad++;
        @(negedge clk);
      end
      check("b2b done seen", {31'd0, done}, 32'd1);
      check("b2b ready held low", 32'(stall_bad), 32'd0);
      check("b2b ready during fin", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("b2b ready after fin", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b loadc wren", 32'(arr_wren), 32'b0010);
      if (arr_wren != '0) wren_cnt++;
      @(negedge clk);
      check("b2b loadc done", {28'd0, arr_wren == '0, arr_en, done, busy}, 32'b1011);
      @(negedge clk);
      check("b2b idle", {30'd0, done, cmd_ready}, 32'b01);
      for (int j = 0; j < 5; j++) begin
        if (arr_wren != '0 || busy) wren_cnt++;
        @(negedge clk);
      end
      check("b2b executes once", 32'(wren_cnt), 32'd1);
    end

    // Reset mid-STREAM at feed_idx 5: immediate clear, no done afterwards.
    begin
      int done_cnt;
      done_cnt = 0;
      issue(2'd1, 2'd0);
      cmd_valid = 1'b0;
      for (int j = 0; j < 40 && feed_idx != CNT_W'(5); j++) @(negedge clk);
      check("reached idx 5", 32'(feed_idx), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("async reset clears", {arr_wren, c_zero, arr_en, feed_valid, done, busy, cmd_ready}, 32'b1);
      check("async reset idx", 32'(feed_idx), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 15; j++) begin
        if (done || busy || arr_en) done_cnt++;
        @(negedge clk);
      end
      check("no activity after abort", 32'(done_cnt), 32'd0);
      run_cmd(vecs[3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
